// File: rtl/saxil_pkg.sv
// rtl/saxil_pkg.sv - shared state encoding and AXI response codes for the AXI4-Lite read arbiter
package saxil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/saxil_read_arbiter.sv
// rtl/saxil_read_arbiter.sv - round-robin share of one AXI4-Lite read slave, one transaction in flight
module saxil_read_arbiter
  import saxil_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          saxil_read_arb_clk,
  input  logic                          saxil_read_arb_rst,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*3-1:0]          s_arprot,
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_arprot,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  output logic                          saxil_read_arb_busy,
  output logic [IDW-1:0]                saxil_read_arb_grant_id
);

  state_t               state, state_nx;
  logic [IDW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;
  logic                 ar_hs;
  logic                 r_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req      (s_arvalid),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .any      (arb_any)
  );

  always_ff @(posedge saxil_read_arb_clk or posedge saxil_read_arb_rst) begin
    if (saxil_read_arb_rst) state <= IDLE;
    else                    state <= state_nx;
  end

  always_comb begin
    state_nx            = state;
    s_arready           = '0;
    s_rvalid            = '0;
    m_arvalid           = 1'b0;
    m_rready            = 1'b0;
    saxil_read_arb_busy = (state != IDLE);
    ar_hs               = 1'b0;
    r_done              = 1'b0;
    case (state)
      IDLE: begin
        s_arready = arb_grant;
        ar_hs     = arb_any;
        if (arb_any) state_nx = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nx = DATA;
      end
      DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_nx = RESP;
      end
      RESP: begin
        s_rvalid[saxil_read_arb_grant_id] = 1'b1;
        r_done = s_rready[saxil_read_arb_grant_id];
        if (r_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Payload registers only load on their own handshake so they hold steady while stalled.
  always_ff @(posedge saxil_read_arb_clk or posedge saxil_read_arb_rst) begin
    if (saxil_read_arb_rst) begin
      rr_ptr                  <= '0;
      saxil_read_arb_grant_id <= '0;
      m_araddr                <= '0;
      m_arprot                <= '0;
      s_rdata                 <= '0;
      s_rresp                 <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        m_araddr                <= s_araddr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        m_arprot                <= s_arprot[int'(arb_idx)*3 +: 3];
        saxil_read_arb_grant_id <= arb_idx;
      end
      if (state == DATA && m_rvalid) begin
        s_rdata <= m_rdata;
        s_rresp <= m_rresp;
      end
      if (r_done) begin
        rr_ptr <= (saxil_read_arb_grant_id == IDW'(NUM_REQ - 1)) ? '0
                                                                  : saxil_read_arb_grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_saxil_read_arbiter.sv
// tb/tb_saxil_read_arbiter.sv - scoreboard bench: random requesters and slave vs a round-robin reference model
module tb_saxil_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*3-1:0]  s_arprot;
  logic [DW-1:0]   s_rdata, m_rdata;
  logic [1:0]      s_rresp, m_rresp;
  logic            m_arvalid, m_arready, m_rvalid, m_rready, busy;
  logic [AW-1:0]   m_araddr;
  logic [2:0]      m_arprot;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  saxil_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .saxil_read_arb_clk(clk), .saxil_read_arb_rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .saxil_read_arb_busy(busy), .saxil_read_arb_grant_id(grant_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  // Expected {rdata, rresp} per requester, pushed when the read is issued
  logic [33:0] exp_q [N][$];
  int          grant_log[$];

  // Slave model: programmable or random stall before arready and before rvalid
  int ar_wait = 0, r_wait = 0, cur_ar = 0, cur_r = 0, sph = 0, scnt = 0;
  bit slv_rand = 0;
  logic [31:0] slv_addr;

  always @(negedge clk) begin
    if (rst) begin
      m_arready = 0; m_rvalid = 0; sph = 0; scnt = 0;
    end else begin
      case (sph)
        0: if (m_arvalid) begin
          if (scnt == 0) begin
            cur_ar = slv_rand ? int'($urandom_range(0, 3)) : ar_wait;
            cur_r  = slv_rand ? int'($urandom_range(0, 3)) : r_wait;
          end
          if (scnt >= cur_ar) begin
            m_arready = 1; slv_addr = m_araddr; sph = 1;
          end else scnt++;
        end
        1: begin
          m_arready = 0; scnt = 0; sph = 2;
          if (cur_r == 0) begin
            m_rvalid = 1; m_rdata = slave_data(slv_addr); m_rresp = slv_addr[9:8]; sph = 3;
          end
        end
        2: begin
          scnt++;
          if (scnt >= cur_r) begin
            m_rvalid = 1; m_rdata = slave_data(slv_addr); m_rresp = slv_addr[9:8]; sph = 3;
          end
        end
        default: begin
          m_rvalid = 0; m_rdata = $urandom; m_rresp = 2'($urandom); sph = 0; scnt = 0;
        end
      endcase
    end
  end

  task automatic do_read(int i, logic [31:0] a, logic [2:0] p, int rdly);
    int t;
    @(negedge clk);
    s_araddr[i*AW +: AW] = a;
    s_arprot[i*3 +: 3]   = p;
    s_arvalid[i]         = 1'b1;
    exp_q[i].push_back({slave_data(a), a[9:8]});
    t = 0; #4;
    while (!s_arready[i] && t < 300) begin @(negedge clk); #4; t++; end
    if (t >= 300) begin
      check("ar_timeout", 0, 1); s_arvalid[i] = 1'b0; return;
    end
    @(negedge clk);
    s_arvalid[i] = 1'b0;
    if (rdly == 0) s_rready[i] = 1'b1;
    t = 0; #4;
    while (!s_rvalid[i] && t < 300) begin @(negedge clk); #4; t++; end
    if (t >= 300) begin
      check("r_timeout", 0, 1); s_rready[i] = 1'b0; return;
    end
    if (rdly > 0) begin
      repeat (rdly) @(negedge clk);
      s_rready[i] = 1'b1;
    end
    @(negedge clk);
    s_rready[i] = 1'b0;
  endtask

  task automatic req_stream(int i, int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_read(i, $urandom & 32'hFFFF_FFFC, 3'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  // Reference model and monitor: sampled 1ns before each rising edge
  int model_ptr = 0, gid_exp = 0;
  logic [31:0] addr_exp;
  logic [2:0]  prot_exp;
  int skipped[N];

  always @(negedge clk) begin
    int w, idx;
    #4;
    if (rst) begin
      model_ptr = 0;
      for (int i = 0; i < N; i++) begin exp_q[i].delete(); skipped[i] = 0; end
    end else begin
      check("arready_onehot", 64'($countones(s_arready) <= 1), 1);
      if (s_arready != 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          idx = (model_ptr + k) % N;
          if (w < 0 && s_arvalid[idx]) w = idx;
        end
        check("arready_while_busy", busy, 0);
        if (w < 0) check("arready_without_req", s_arready, 0);
        else begin
          check("grant_winner", s_arready, 64'(1) << w);
          gid_exp  = w;
          addr_exp = s_araddr[w*AW +: AW];
          prot_exp = s_arprot[w*3 +: 3];
          grant_log.push_back(w);
          for (int j = 0; j < N; j++) begin
            if (j == w) skipped[j] = 0;
            else if (s_arvalid[j]) begin
              skipped[j]++;
              check("no_starvation", 64'(skipped[j] < N), 1);
            end
          end
        end
      end
      if (m_arvalid) begin
        check("m_araddr", m_araddr, addr_exp);
        check("m_arprot", m_arprot, prot_exp);
      end
      if (s_rvalid != 0) begin
        check("s_rvalid_onehot", s_rvalid, 64'(1) << gid_exp);
        check("grant_id", grant_id, gid_exp);
        if (exp_q[gid_exp].size() == 0) check("unexpected_response", 0, 1);
        else begin
          check("s_rdata", s_rdata, exp_q[gid_exp][0][33:2]);
          check("s_rresp", s_rresp, exp_q[gid_exp][0][1:0]);
          if (s_rready[gid_exp]) begin
            void'(exp_q[gid_exp].pop_front());
            model_ptr = (gid_exp + 1) % N;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1; s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arprot = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_busy", busy, 0);          check("rst_grant_id", grant_id, 0);
    check("rst_m_arvalid", m_arvalid, 0); check("rst_m_rready", m_rready, 0);
    check("rst_s_rvalid", s_rvalid, 0);  check("rst_m_araddr", m_araddr, 0);
    check("rst_s_rdata", s_rdata, 0);    check("rst_s_arready", s_arready, 0);
    @(negedge clk); rst = 0;

    do_read(1, 32'h0000_0040, 3'b010, 0);
    check("t1_grant_id", grant_id, 1);
    do_read(3, 32'h0000_1000, 3'b001, 4);

    grant_log.delete();
    fork
      begin do_read(0, 32'h10, 3'd0, 0); do_read(0, 32'h14, 3'd4, 1); end
      do_read(1, 32'h20, 3'd1, 0);
      do_read(2, 32'h30, 3'd2, 2);
      do_read(3, 32'h3C, 3'd3, 0);
    join
    check("t2_grant_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      for (int k = 0; k < 5; k++) check("t2_grant_order", grant_log[k], k % 4);
    end

    ar_wait = 5; r_wait = 3;
    fork
      do_read(2, 32'hABCD_0044, 3'd6, 0);
      begin repeat (2) @(negedge clk); do_read(0, 32'h0000_0888, 3'd5, 1); end
    join
    ar_wait = 0; r_wait = 0;

    do_read(1, 32'h0000_0200, 3'd0, 0);
    do_read(2, 32'h0000_0300, 3'd0, 0);
    do_read(3, 32'h0000_0100, 3'd0, 2);

    slv_rand = 1;
    fork
      req_stream(0, 12); req_stream(1, 12); req_stream(2, 12); req_stream(3, 12);
    join
    slv_rand = 0;

    do_read(0, 32'h0000_0500, 3'd0, 0);
    r_wait = 20;
    @(negedge clk);
    s_araddr[2*AW +: AW] = 32'h80; s_arvalid[2] = 1'b1;
    t = 0; #4;
    while (!m_rready && t < 50) begin @(negedge clk); #4; t++; end
    check("t6_reach_data", m_rready, 1);
    @(posedge clk); #2;
    rst = 1; s_arvalid = '0;
    #1;
    check("t6_rst_m_rready", m_rready, 0);
    check("t6_rst_s_rvalid", s_rvalid, 0);
    check("t6_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0; r_wait = 0;
    fork
      do_read(0, 32'h0000_0600, 3'd0, 0);
      do_read(3, 32'h0000_0700, 3'd0, 0);
      begin @(negedge clk); #4; check("t6_rst_priority", s_arready, 4'b0001); end
    join

    repeat (5) @(negedge clk);
    for (int i = 0; i < N; i++) check("queue_drained", exp_q[i].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
